// File: rtl/palindrome_check_scheduler_if.sv
// Request/result bundle for palindrome_check_scheduler.
// The master side holds the requesters and the result consumer; the slave side is the scheduler.
interface palindrome_check_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*WIDTH-1:0]   req_num;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       res_valid;
    logic                       res_ready;
    logic                       res_is_pal;
    logic [$clog2(NUM_REQ)-1:0] res_id;
    logic [WIDTH-1:0]           res_num;

    modport master (
        output req_valid, req_num, res_ready,
        input  req_ready, res_valid, res_is_pal, res_id, res_num
    );

    modport slave (
        input  req_valid, req_num, res_ready,
        output req_ready, res_valid, res_is_pal, res_id, res_num
    );
endinterface

// File: rtl/palindrome_check_scheduler.sv
// Round-robin shared serial bit-palindrome checker, one mirrored bit pair per clock.
// Define PAL_EARLY_EXIT_EN to finish a check on the first mismatching pair.
module palindrome_check_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    palindrome_check_scheduler_if.slave bus,
    output logic                       busy
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH / 2 - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_found;
    logic [IDX_W-1:0] idx;
    logic             match;
    logic [WIDTH-1:0] num_rev;
    logic             bit_ok;
    logic             next_match;
    logic             finish;

    // Search starts just past the previous winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_found && bus.req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && grant_found) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            num_rev[i] = bus.res_num[WIDTH-1-i];
        end
    end

    assign bit_ok     = (bus.res_num[idx] == num_rev[idx]);
    assign next_match = match & bit_ok;

`ifdef PAL_EARLY_EXIT_EN
    assign finish = !bit_ok || (idx == LAST_IDX);
`else
    assign finish = (idx == LAST_IDX);
`endif

    assign busy = (state != IDLE);

    // The captured number doubles as the result field, so it stays stable through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_grant     <= ID_W'(NUM_REQ - 1);
            idx            <= '0;
            match          <= 1'b0;
            bus.res_valid  <= 1'b0;
            bus.res_is_pal <= 1'b0;
            bus.res_id     <= '0;
            bus.res_num    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        bus.res_num <= bus.req_num[int'(grant_idx)*WIDTH +: WIDTH];
                        bus.res_id  <= grant_idx;
                        last_grant  <= grant_idx;
                        idx         <= '0;
                        match       <= 1'b1;
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    match <= next_match;
                    if (finish) begin
                        bus.res_is_pal <= next_match;
                        bus.res_valid  <= 1'b1;
                        state          <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_palindrome_check_scheduler.sv
// Scoreboard bench for palindrome_check_scheduler: a transaction-level predictor pushes
// expected results, a monitor pops them on each result handshake.
module tb_palindrome_check_scheduler;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int ID_W    = $clog2(NUM_REQ);

    logic clk;
    logic rst_n;
    logic busy;

    palindrome_check_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

    palindrome_check_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic             pal;
        logic [WIDTH-1:0] num;
    } res_t;

    int   checks   = 0;
    int   failures = 0;
    res_t exp_q[$];
    res_t log_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Index of the first unequal mirrored pair, or -1 for a palindrome.
    function automatic int first_mismatch(input logic [WIDTH-1:0] n);
        for (int i = 0; i < WIDTH / 2; i++) begin
            if (n[i] != n[WIDTH-1-i]) return i;
        end
        return -1;
    endfunction

    function automatic int check_latency(input int fm);
`ifdef PAL_EARLY_EXIT_EN
        if (fm >= 0) return fm + 1;
`endif
        return WIDTH / 2;
    endfunction

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Predictor: engine is free, working for a known number of edges, or holding a result.
    localparam int M_IDLE = 0;
    localparam int M_WORK = 1;
    localparam int M_DONE = 2;

    initial begin
        int               mst;
        int               mlast;
        int               mcnt;
        int               g;
        int               fm;
        res_t             cur;
        logic [NUM_REQ-1:0] er;
        logic [WIDTH-1:0] n;
        mst   = M_IDLE;
        mlast = NUM_REQ - 1;
        mcnt  = 0;
        cur   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mst   = M_IDLE;
                mlast = NUM_REQ - 1;
                exp_q.delete();
            end else if (mst == M_IDLE) begin
                g  = pick(bus.req_valid, mlast);
                er = '0;
                if (g >= 0) er[g] = 1'b1;
                checkOutput("req_ready_idle", 64'(bus.req_ready), 64'(er));
                checkOutput("busy_idle", 64'(busy), 64'd0);
                checkOutput("res_valid_idle", 64'(bus.res_valid), 64'd0);
                if (g >= 0) begin
                    n       = bus.req_num[g*WIDTH +: WIDTH];
                    fm      = first_mismatch(n);
                    cur.id  = ID_W'(g);
                    cur.num = n;
                    cur.pal = (fm < 0);
                    exp_q.push_back(cur);
                    mlast = g;
                    mcnt  = check_latency(fm) + 1;
                    mst   = M_WORK;
                end
            end else begin
                if (mst == M_WORK) begin
                    mcnt--;
                    if (mcnt == 0) begin
                        mst = M_DONE;
                    end else begin
                        checkOutput("res_valid_work", 64'(bus.res_valid), 64'd0);
                        checkOutput("busy_work", 64'(busy), 64'd1);
                        checkOutput("req_ready_work", 64'(bus.req_ready), 64'd0);
                    end
                end
                if (mst == M_DONE) begin
                    checkOutput("res_valid_done", 64'(bus.res_valid), 64'd1);
                    checkOutput("busy_done", 64'(busy), 64'd1);
                    checkOutput("req_ready_done", 64'(bus.req_ready), 64'd0);
                    if (!bus.res_ready) begin
                        checkOutput("hold_res_id", 64'(bus.res_id), 64'(cur.id));
                        checkOutput("hold_res_is_pal", 64'(bus.res_is_pal), 64'(cur.pal));
                        checkOutput("hold_res_num", 64'(bus.res_num), 64'(cur.num));
                    end else begin
                        mst = M_IDLE;
                    end
                end
            end
        end
    end

    // Monitor: every accepted result is matched against the oldest expectation.
    initial begin
        res_t act;
        res_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.res_valid && bus.res_ready) begin
                act.id  = bus.res_id;
                act.pal = bus.res_is_pal;
                act.num = bus.res_num;
                log_q.push_back(act);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_result: got id=%0d num=0x%0h required none", act.id, act.num);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("res_id", 64'(act.id), 64'(e.id));
                    checkOutput("res_is_pal", 64'(act.pal), 64'(e.pal));
                    checkOutput("res_num", 64'(act.num), 64'(e.num));
                end
            end
        end
    end

    task automatic tick();
        logic [NUM_REQ-1:0] granted;
        @(negedge clk);
        granted = bus.req_ready;
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~granted;
    endtask

    task automatic applyStimulus(input int id, input logic [WIDTH-1:0] n);
        bus.req_num[id*WIDTH +: WIDTH] = n;
        bus.req_valid[id] = 1'b1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((bus.req_valid != '0 || busy || bus.res_valid) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: timeout after %0d cycles, engine still busy", name, n);
        end
    endtask

    // Returns the number of ticks until res_valid is seen.
    task automatic wait_valid(input int budget, input string name, output int n);
        n = 0;
        while (!bus.res_valid && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: timeout after %0d cycles waiting for res_valid", name, n);
        end
    endtask

    task automatic expect_log(input string name, input int pos, input int id, input bit pal);
        if (pos >= log_q.size()) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: result %0d missing, got %0d results", name, pos, log_q.size());
        end else begin
            checkOutput({name, "_id"}, 64'(log_q[pos].id), 64'(id));
            checkOutput({name, "_pal"}, 64'(log_q[pos].pal), 64'(pal));
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_num();
        logic [WIDTH-1:0] n;
        n = WIDTH'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < WIDTH / 2; i++) n[WIDTH-1-i] = n[i];
        end
        return n;
    endfunction

    initial begin
        #200000;
        checks++;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int lat;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_num   = '0;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_res_valid", 64'(bus.res_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_res_is_pal", 64'(bus.res_is_pal), 64'd0);
        checkOutput("reset_res_id", 64'(bus.res_id), 64'd0);
        checkOutput("reset_res_num", 64'(bus.res_num), 64'd0);
        rst_n = 1'b1;

        $display("[TB] reset in the middle of a check");
        applyStimulus(1, 8'h99);
        tick();
        tick();
        checkOutput("mid_check_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_res_valid", 64'(bus.res_valid), 64'd0);
        checkOutput("async_reset_busy", 64'(busy), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        log_q.delete();
        applyStimulus(0, 8'hE7);
        applyStimulus(1, 8'h08);
        applyStimulus(2, 8'h81);
        applyStimulus(3, 8'h3C);
        #1;
        checkOutput("first_grant_after_reset", 64'(bus.req_ready), 64'h1);
        wait_idle(200, "four_requesters");
        checkOutput("four_requesters_count", 64'(log_q.size()), 64'd4);
        expect_log("order0", 0, 0, 1'b1);
        expect_log("order1", 1, 1, 1'b0);
        expect_log("order2", 2, 2, 1'b1);
        expect_log("order3", 3, 3, 1'b1);

        $display("[TB] single palindrome and early mismatch");
        log_q.delete();
        applyStimulus(0, 8'h5A);
        wait_valid(50, "pal_5a_latency", lat);
        checkOutput("pal_5a_latency", 64'(lat), 64'(WIDTH / 2 + 1));
        wait_idle(50, "pal_5a");
        expect_log("pal_5a", 0, 0, 1'b1);
        if (log_q.size() > 0) checkOutput("pal_5a_num", 64'(log_q[0].num), 64'h5A);

        log_q.delete();
        applyStimulus(2, 8'hCA);
        wait_valid(50, "mis_ca_latency", lat);
`ifdef PAL_EARLY_EXIT_EN
        checkOutput("mis_ca_latency", 64'(lat), 64'd2);
`else
        checkOutput("mis_ca_latency", 64'(lat), 64'(WIDTH / 2 + 1));
`endif
        wait_idle(50, "mis_ca");
        expect_log("mis_ca", 0, 2, 1'b0);

        $display("[TB] result backpressure");
        log_q.delete();
        bus.res_ready = 1'b0;
        applyStimulus(3, 8'h99);
        wait_valid(50, "backpressure_valid", lat);
        applyStimulus(0, 8'h11);
        applyStimulus(1, 8'h22);
        repeat (10) tick();
        checkOutput("backpressure_req_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("backpressure_res_valid", 64'(bus.res_valid), 64'd1);
        bus.res_ready = 1'b1;
        wait_idle(100, "backpressure");
        expect_log("bp0", 0, 3, 1'b1);
        expect_log("bp1", 1, 0, 1'b0);
        expect_log("bp2", 2, 1, 1'b0);

        $display("[TB] rotation after requester 3");
        applyStimulus(3, 8'h42);
        wait_idle(50, "rot_prime");
        log_q.delete();
        applyStimulus(0, 8'h3C);
        applyStimulus(3, 8'hA5);
        wait_idle(100, "rotation");
        expect_log("rot0", 0, 0, 1'b1);
        expect_log("rot1", 1, 3, 1'b1);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            bus.res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 5) == 0) begin
                    applyStimulus(i, rand_num());
                end else if (bus.req_valid[i] && $urandom_range(0, 39) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            tick();
        end
        bus.res_ready = 1'b1;
        wait_idle(400, "random_drain");
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
